decoder_scan_seq: RTL and testbench

//   Upstream sequencer for the 3-to-8 line decoder. Steps the decoder select

---
 rtl/decoder_scan_seq.sv | 131 +++++++++++++
 tb/tb_decoder_scan_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 3-to-8 line decoder.
// Steps the select lines {c,b,a} through 0..last_idx and holds each index
// for a programmable dwell. It runs either a single pass or a continuous scan.
module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  input  logic               cont,
  input  logic [2:0]         last_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               en,
  output logic               step_stb,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_n;
  logic [2:0]         idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_r, dwell_r_n;
  logic [2:0]         last_r, last_r_n;
  logic               cont_r, cont_r_n;
  logic               en_n, step_n, busy_n, done_n;
  logic [DWELL_W-1:0] dwell_sat;

  // A dwell of zero would leave no cycle per index, so it is clamped to one.
  function automatic logic [DWELL_W-1:0] dwell_clamp(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  assign dwell_sat = dwell_clamp(dwell);

  // The select lines come straight from the registered index.
  assign a = idx[0];
  assign b = idx[1];
  assign c = idx[2];

  // Control state and registered outputs; the reset applies here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      en       <= 1'b0;
      step_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      en       <= en_n;
      step_stb <= step_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Dwell counter and latched configuration. These are only read in RUN,
  // and RUN is always entered through a load, so they need no reset.
  always_ff @(posedge clk) begin
    cnt     <= cnt_n;
    dwell_r <= dwell_r_n;
    last_r  <= last_r_n;
    cont_r  <= cont_r_n;
  end

  // Next-state logic: abort beats hold, and hold beats advance.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    dwell_r_n = dwell_r;
    last_r_n  = last_r;
    cont_r_n  = cont_r;
    en_n      = en;
    busy_n    = busy;
    step_n    = 1'b0;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n   = RUN;
          dwell_r_n = dwell_sat;
          last_r_n  = last_idx;
          cont_r_n  = cont;
          idx_n     = 3'd0;
          cnt_n     = dwell_sat - DWELL_W'(1);
          en_n      = 1'b1;
          busy_n    = 1'b1;
          step_n    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          en_n    = 1'b0;
          busy_n  = 1'b0;
        end else if (hold) begin
          state_n = RUN;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (idx != last_r) begin
          idx_n  = idx + 3'd1;
          cnt_n  = dwell_r - DWELL_W'(1);
          step_n = 1'b1;
        end else if (cont_r) begin
          idx_n  = 3'd0;
          cnt_n  = dwell_r - DWELL_W'(1);
          step_n = 1'b1;
        end else begin
          state_n = IDLE;
          idx_n   = 3'd0;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq.
// A behavioural reference model predicts the outputs for every cycle.
// The predictions are queued when the inputs are driven, then popped and
// compared once the DUT has clocked.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort, hold, cont;
  logic [2:0] last_idx;
  logic [7:0] dwell;
  logic       a, b, c, en, step_stb, busy, done;

  always #5 clk = ~clk;

  decoder_scan_seq #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .cont(cont), .last_idx(last_idx), .dwell(dwell),
    .a(a), .b(b), .c(c), .en(en), .step_stb(step_stb), .busy(busy),
    .done(done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_step, n_en, n_done, n_idx2;

  logic [6:0] exp_q[$];

  // Reference model state. The dwell position counts up (age), not down.
  bit m_run, m_cont, m_step, m_done;
  int m_idx, m_age, m_dw, m_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    m_step = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_idx = 0; m_age = 0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run  = 1'b1;
        m_dw   = (dwell > 0) ? int'(dwell) : 1;
        m_last = int'(last_idx);
        m_cont = cont;
        m_idx  = 0;
        m_age  = 0;
        m_step = 1'b1;
      end
    end else if (abort) begin
      m_run = 1'b0; m_idx = 0;
    end else if (!hold) begin
      if (m_age + 1 < m_dw) m_age++;
      else if (m_idx < m_last) begin
        m_idx++; m_age = 0; m_step = 1'b1;
      end else if (m_cont) begin
        m_idx = 0; m_age = 0; m_step = 1'b1;
      end else begin
        m_run = 1'b0; m_idx = 0; m_done = 1'b1;
      end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] i3;
    i3 = m_idx[2:0];
    return {i3, m_run, m_step, m_run, m_done};
  endfunction

  task automatic cycle();
    logic [6:0] got, e;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    got = {c, b, a, en, step_stb, busy, done};
    e = exp_q.pop_front();
    check_val("cycle_outputs", 32'(got), 32'(e));
    if (step_stb) n_step++;
    if (en) n_en++;
    if (done) n_done++;
    if (en && {c, b, a} == 3'd2) n_idx2++;
  endtask

  task automatic clr_counts();
    n_step = 0; n_en = 0; n_done = 0; n_idx2 = 0;
  endtask

  task automatic run_until_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      cycle();
      if (done) seen = 1'b1;
    end
    check_val("done_within_bound", 32'(seen), 32'd1);
  endtask

  task automatic start_scan(input logic [7:0] dw, input logic [2:0] li, input logic ct);
    dwell = dw; last_idx = li; cont = ct; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; cont = 1'b0;
    last_idx = 3'd0; dwell = 8'd1;
    cycle();
    cycle();
    check_val("reset_state", 32'({c, b, a, en, step_stb, busy, done}), 32'd0);
    rst = 1'b0;
    cycle();

    // Reset asserted for two cycles in the middle of a scan.
    start_scan(8'd3, 3'd7, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    rst = 1'b1;
    cycle();
    check_val("rst_mid_scan", 32'({c, b, a, en, step_stb, busy, done}), 32'd0);
    cycle();
    check_val("rst_second_cycle", 32'({c, b, a, en, step_stb, busy, done}), 32'd0);
    rst = 1'b0;
    cycle();

    // Full single pass: dwell 3 over indices 0..7.
    clr_counts();
    start_scan(8'd3, 3'd7, 1'b0);
    run_until_done(40);
    check_val("pass8_steps", 32'(n_step), 32'd8);
    check_val("pass8_en_cycles", 32'(n_en), 32'd24);
    check_val("pass8_done_pulses", 32'(n_done), 32'd1);
    check_val("pass8_done_en_low", 32'(en), 32'd0);
    cycle();

    // A dwell of zero behaves as one cycle per index.
    clr_counts();
    start_scan(8'd0, 3'd2, 1'b0);
    run_until_done(10);
    check_val("dw0_steps", 32'(n_step), 32'd3);
    check_val("dw0_en_cycles", 32'(n_en), 32'd3);
    check_val("dw0_done_pulses", 32'(n_done), 32'd1);
    cycle();

    // Continuous scan wraps the index, then an abort lands mid-index.
    clr_counts();
    start_scan(8'd2, 3'd1, 1'b1);
    for (int i = 0; i < 8; i++) cycle();
    check_val("cont_steps", 32'(n_step), 32'd5);
    check_val("cont_no_done", 32'(n_done), 32'd0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check_val("abort_en", 32'(en), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    cycle();
    cycle();

    // Hold for 5 cycles at idx 2 stretches it; a start during RUN is ignored.
    clr_counts();
    start_scan(8'd4, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    start = 1'b1; dwell = 8'd1; last_idx = 3'd0; cont = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      cycle();
    end
    start = 1'b0;
    hold = 1'b0;
    run_until_done(30);
    check_val("hold_idx2_len", 32'(n_idx2), 32'd9);
    check_val("hold_steps", 32'(n_step), 32'd4);
    check_val("hold_en_cycles", 32'(n_en), 32'd21);
    check_val("hold_done_pulses", 32'(n_done), 32'd1);
    cycle();

    // Start and abort together in IDLE leave the sequencer idle.
    start = 1'b1; abort = 1'b1; dwell = 8'd2; last_idx = 3'd3; cont = 1'b0;
    cycle();
    start = 1'b0; abort = 1'b0;
    check_val("start_abort_busy", 32'(busy), 32'd0);
    check_val("start_abort_en", 32'(en), 32'd0);

    // A start on the done cycle launches a new scan on the next cycle.
    start_scan(8'd1, 3'd0, 1'b0);
    cycle();
    check_val("done_cycle_pulse", 32'(done), 32'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_val("restart_busy", 32'(busy), 32'd1);
    check_val("restart_step", 32'(step_stb), 32'd1);
    check_val("restart_idx", 32'({c, b, a}), 32'd0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
